// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU link: op codes, word types,
// frame geometry and the CRC-4 used by both tester and receiver.
package alu_pkg;

  typedef enum logic [2:0] {
    AND_OP = 3'b000,
    OR_OP  = 3'b001,
    ADD_OP = 3'b100,
    SUB_OP = 3'b101,
    NO_OP  = 3'b111
  } operation_t;

  localparam logic WORD_DATA = 1'b0;
  localparam logic WORD_CTL  = 1'b1;

  localparam int unsigned BITS_PER_WORD   = 11;
  localparam int unsigned WORDS_PER_FRAME = 9;
  localparam int unsigned BITS_PER_FRAME  = BITS_PER_WORD * WORDS_PER_FRAME;

  // CRC-4, polynomial x^4+x+1, seed 0, data consumed MSB first.
  function automatic logic [3:0] crc4_68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ d[67-i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Ops the ALU core actually implements.
  function automatic logic op_is_valid(input logic [2:0] op);
    case (op)
      AND_OP, OR_OP, ADD_OP, SUB_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_rx_word.sv
// Bit-level sampler for one 11-bit word after its start bit has been seen:
// captures type and payload, flags the stop bit on the done cycle.
module alu_serial_word_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       start,
  output logic       done,
  output logic       word_type,
  output logic [7:0] payload,
  output logic       stop_ok
);

  typedef enum logic [1:0] {W_IDLE, W_TYPE, W_PAYLOAD, W_STOP} wstate_t;

  wstate_t    state, state_n;
  logic [2:0] bit_cnt;

  // State register plus type/payload capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= W_IDLE;
      word_type <= 1'b0;
      payload   <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_n;
      case (state)
        W_TYPE: begin
          word_type <= sin;
          bit_cnt   <= 3'd7;
        end
        W_PAYLOAD: begin
          payload <= {payload[6:0], sin};
          bit_cnt <= bit_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Next state; done marks the cycle in which the stop bit is on sin.
  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      W_IDLE:    if (start) state_n = W_TYPE;
      W_TYPE:    state_n = W_PAYLOAD;
      W_PAYLOAD: if (bit_cnt == 3'd0) state_n = W_STOP;
      W_STOP: begin
        done    = 1'b1;
        state_n = W_IDLE;
      end
      default:   state_n = W_IDLE;
    endcase
  end

  assign stop_ok = sin;

endmodule

// File: rtl/alu_serial_rx.sv
// Frame receiver: sequences 8 data words plus CTL, assembles A/B/op,
// checks framing, op code and CRC-4, and reports with a one-cycle valid.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WORDS  = 8,
  parameter int unsigned GAP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic        valid_o,
  output logic        err_data_o,
  output logic        err_crc_o,
  output logic        err_op_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WORD, GAP, REPORT} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(DATA_WORDS);
  localparam logic [15:0] GAP_LIM  = 16'(GAP_TIMEOUT);

  state_t      state, state_n;
  logic        word_start, word_done, word_type, stop_ok;
  logic [7:0]  word_byte;
  logic [3:0]  word_cnt;
  logic [15:0] gap_cnt;
  logic [63:0] data_q;
  logic [7:0]  ctl_q;
  logic        err_q;
  logic        store_data, store_ctl, report_err;

  alu_serial_word_rx u_word (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .start     (word_start),
    .done      (word_done),
    .word_type (word_type),
    .payload   (word_byte),
    .stop_ok   (stop_ok)
  );

  // Frame sequencing: start detection, per-word decisions, gap timeout.
  always_comb begin
    state_n    = state;
    word_start = 1'b0;
    store_data = 1'b0;
    store_ctl  = 1'b0;
    report_err = 1'b0;
    case (state)
      IDLE: begin
        if (!sin) begin
          word_start = 1'b1;
          state_n    = WORD;
        end
      end
      WORD: begin
        if (word_done) begin
          state_n = REPORT;
          if (!stop_ok) begin
            report_err = 1'b1;
          end else if (word_type == WORD_DATA) begin
            if (word_cnt < LAST_CNT) begin
              store_data = 1'b1;
              state_n    = GAP;
            end else begin
              report_err = 1'b1;
            end
          end else if (word_cnt != LAST_CNT) begin
            report_err = 1'b1;
          end else begin
            store_ctl = 1'b1;
          end
        end
      end
      GAP: begin
        if (!sin) begin
          word_start = 1'b1;
          state_n    = WORD;
        end else if ((GAP_TIMEOUT != 0) && (gap_cnt == GAP_LIM)) begin
          report_err = 1'b1;
          state_n    = REPORT;
        end
      end
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sequencer registers; data bytes shift in so that after 8 words
  // data_q holds {B, A} in transmission order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      gap_cnt  <= '0;
      data_q   <= '0;
      ctl_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == REPORT)  word_cnt <= '0;
      else if (store_data)  word_cnt <= word_cnt + 4'd1;
      if (state != GAP)     gap_cnt <= '0;
      else                  gap_cnt <= gap_cnt + 16'd1;
      if (store_data)       data_q <= {data_q[55:0], word_byte};
      if (store_ctl)        ctl_q  <= word_byte;
      if (state != REPORT && state_n == REPORT) err_q <= report_err;
    end
  end

  // Report registers: loaded in REPORT, held until the next report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o        <= '0;
      b_o        <= '0;
      op_o       <= '0;
      valid_o    <= 1'b0;
      err_data_o <= 1'b0;
      err_crc_o  <= 1'b0;
      err_op_o   <= 1'b0;
    end else begin
      valid_o <= (state == REPORT);
      if (state == REPORT) begin
        if (err_q) begin
          a_o        <= '0;
          b_o        <= '0;
          op_o       <= '0;
          err_data_o <= 1'b1;
          err_crc_o  <= 1'b0;
          err_op_o   <= 1'b0;
        end else begin
          a_o        <= data_q[31:0];
          b_o        <= data_q[63:32];
          op_o       <= ctl_q[6:4];
          err_data_o <= 1'b0;
          err_crc_o  <= (crc4_68({data_q, 1'b1, ctl_q[6:4]}) != ctl_q[3:0]);
          err_op_o   <= !op_is_valid(ctl_q[6:4]);
        end
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule
